// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port synchronous RAM.
// Grants are combinational. Simultaneous requests are resolved round-robin,
// except that a port already on a run of two or more grants may continue
// until it has taken MAX_BURST grants in a row. Read data returns one cycle
// after the grant and is steered to the requesting port by a registered tag.
module ram_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4,
    localparam int ADDR     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             we_a,
    input  logic             we_b,
    input  logic [ADDR-1:0]  addr_a,
    input  logic [ADDR-1:0]  addr_b,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             ram_enable,
    output logic             ram_read_en,
    output logic [ADDR-1:0]  ram_address,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    localparam int BW = $clog2(MAX_BURST + 1);

    logic          r_last;       // 0 = A granted most recently, 1 = B
    logic [BW-1:0] r_burst;      // consecutive grants to r_last, saturating
    logic          r_tag_valid;  // a read was granted last cycle
    logic          r_tag_port;   // which port that read belongs to

    logic             w_tie;
    logic             w_hold;
    logic             w_sel_b;
    logic             w_any;
    logic             w_we_sel;
    logic [ADDR-1:0]  w_addr_sel;
    logic [WIDTH-1:0] w_wdata_sel;

    // Arbitration: a tie stays with the last winner only mid-burst
    // (run length 2..MAX_BURST-1); a run of one alternates.
    always_comb begin
        w_tie       = req_a & req_b;
        w_hold      = (r_burst > BW'(1)) && (r_burst < BW'(MAX_BURST));
        w_sel_b     = w_tie ? (w_hold ? r_last : ~r_last) : req_b;
        w_any       = ~rst & (req_a | req_b);
        gnt_a       = w_any & ~w_sel_b;
        gnt_b       = w_any & w_sel_b;
        w_we_sel    = w_sel_b ? we_b    : we_a;
        w_addr_sel  = w_sel_b ? addr_b  : addr_a;
        w_wdata_sel = w_sel_b ? wdata_b : wdata_a;
    end

    // RAM strobes follow the granted port; parked at read/zero when idle.
    always_comb begin
        ram_enable  = w_any;
        ram_read_en = w_any ? ~w_we_sel : 1'b1;
        ram_address = w_any ? w_addr_sel : '0;
        ram_data_in = w_any ? w_wdata_sel : '0;
    end

    // Read response steering; reset in the response cycle drops the data.
    always_comb begin
        rvalid_a = ~rst & r_tag_valid & ~r_tag_port;
        rvalid_b = ~rst & r_tag_valid & r_tag_port;
        rdata_a  = rvalid_a ? ram_data_out : '0;
        rdata_b  = rvalid_b ? ram_data_out : '0;
    end

    // Last-grant pointer, burst counter and response tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_burst     <= '0;
            r_tag_valid <= 1'b0;
            r_tag_port  <= 1'b0;
        end else begin
            r_tag_valid <= w_any & ~w_we_sel;
            r_tag_port  <= w_sel_b;
            if (w_any) begin
                r_last <= w_sel_b;
                if (w_sel_b != r_last) begin
                    r_burst <= BW'(1);
                end else if (r_burst < BW'(MAX_BURST)) begin
                    r_burst <= r_burst + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios followed by random traffic, checked
// against a transaction-level model (winner rule, shadow memory, pending read).
module tb_ram_arbiter;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 4;
    localparam int ADDR      = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst, req_a, req_b, we_a, we_b;
    logic [ADDR-1:0]  addr_a, addr_b;
    logic [WIDTH-1:0] wdata_a, wdata_b;
    logic             gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic             ram_enable, ram_read_en;
    logic [ADDR-1:0]  ram_address;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out = '0;

    logic [WIDTH-1:0] ram_mem [DEPTH];
    logic [WIDTH-1:0] mdl_mem [DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    int               m_last   = 1;
    int               m_streak = 0;
    logic             p_valid  = 1'b0;
    int               p_port   = 0;
    logic [WIDTH-1:0] p_data   = '0;

    // observations from the latest step, for directed constant checks
    logic             o_ga, o_gb, o_rva, o_rvb;
    logic [WIDTH-1:0] o_rda, o_rdb;

    always #5 clk = ~clk;

    ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_enable(ram_enable), .ram_read_en(ram_read_en),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // behavioural synchronous RAM with registered read data
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_read_en) ram_data_out <= ram_mem[ram_address];
            else             ram_mem[ram_address] <= ram_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ra, input logic rb,
                        input logic wa, input logic wb,
                        input logic [ADDR-1:0] aa, input logic [ADDR-1:0] ab,
                        input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        int               win;
        logic             w_we;
        logic [ADDR-1:0]  w_ad;
        logic [WIDTH-1:0] w_dt;
        logic             e_rva, e_rvb;
        @(negedge clk);
        rst = r; req_a = ra; req_b = rb; we_a = wa; we_b = wb;
        addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
        #1;
        win = -1;
        if (!r && ra && rb)
            win = (m_streak >= 2 && m_streak < MAX_BURST) ? m_last : 1 - m_last;
        else if (!r && ra) win = 0;
        else if (!r && rb) win = 1;
        w_we = (win == 1) ? wb : wa;
        w_ad = (win == 1) ? ab : aa;
        w_dt = (win == 1) ? db : da;
        e_rva = !r && p_valid && p_port == 0;
        e_rvb = !r && p_valid && p_port == 1;
        check("gnt_a", gnt_a, win == 0);
        check("gnt_b", gnt_b, win == 1);
        check("ram_enable", ram_enable, win >= 0);
        check("ram_read_en", ram_read_en, (win >= 0) ? !w_we : 1'b1);
        check("ram_address", ram_address, (win >= 0) ? w_ad : '0);
        check("ram_data_in", ram_data_in, (win >= 0) ? w_dt : '0);
        check("rvalid_a", rvalid_a, e_rva);
        check("rvalid_b", rvalid_b, e_rvb);
        check("rdata_a", rdata_a, e_rva ? p_data : '0);
        check("rdata_b", rdata_b, e_rvb ? p_data : '0);
        o_ga = gnt_a; o_gb = gnt_b; o_rva = rvalid_a; o_rvb = rvalid_b;
        o_rda = rdata_a; o_rdb = rdata_b;
        @(posedge clk);
        p_valid = 1'b0;
        if (r) begin
            m_last = 1;
            m_streak = 0;
        end else if (win >= 0) begin
            if (win == m_last) m_streak = (m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST;
            else               m_streak = 1;
            m_last = win;
            if (w_we) mdl_mem[w_ad] = w_dt;
            else begin
                p_valid = 1'b1;
                p_port  = win;
                p_data  = mdl_mem[w_ad];
            end
        end
    endtask

    task automatic idle(input logic r);
        step(r, 0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic mem_compare(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, ram_mem[i], mdl_mem[i]);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = '0;
            mdl_mem[i] = '0;
        end
        rst = 1'b1; req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

        // reset with requests present: nothing granted
        step(1, 1, 1, 0, 0, 4'd1, 4'd2, '0, '0);
        step(1, 1, 1, 0, 0, 4'd1, 4'd2, '0, '0);
        check("rst_gnt", {o_ga, o_gb}, 2'b00);

        // write then read back on port A
        step(0, 1, 0, 1, 0, 4'd3, '0, 8'h5A, '0);
        check("wr_gnt_a", o_ga, 1'b1);
        step(0, 1, 0, 0, 0, 4'd3, '0, '0, '0);
        check("rd_gnt_a", o_ga, 1'b1);
        idle(0);
        check("rd_rvalid_a", o_rva, 1'b1);
        check("rd_rdata_a", o_rda, 8'h5A);

        // sustained tie alternates A,B,A,B...
        idle(1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 0, 0, 4'(i), 4'(i + 1), '0, '0);
            check("tie_alt", {o_ga, o_gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        idle(0);

        // long solo run on A saturates burst: first tie goes to B
        idle(1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 4'(i), '0, '0, '0);
        step(0, 1, 1, 0, 0, 4'd1, 4'd2, '0, '0);
        check("burst_sat_tie_b", o_gb, 1'b1);
        idle(0);

        // short solo run on A continues through ties until burst of 4
        idle(1);
        step(0, 1, 0, 0, 0, 4'd0, '0, '0, '0);
        step(0, 1, 0, 0, 0, 4'd1, '0, '0, '0);
        step(0, 1, 1, 0, 0, 4'd2, 4'd2, '0, '0);
        check("burst_cont_3", o_ga, 1'b1);
        step(0, 1, 1, 0, 0, 4'd3, 4'd3, '0, '0);
        check("burst_cont_4", o_ga, 1'b1);
        step(0, 1, 1, 0, 0, 4'd4, 4'd4, '0, '0);
        check("burst_switch_b", o_gb, 1'b1);
        idle(0);

        // back-to-back reads on different ports
        step(0, 1, 0, 1, 0, 4'd7, '0, 8'h11, '0);
        step(0, 1, 0, 1, 0, 4'd8, '0, 8'h22, '0);
        step(0, 1, 0, 0, 0, 4'd7, '0, '0, '0);
        step(0, 0, 1, 0, 0, '0, 4'd8, '0, '0);
        check("b2b_rvalid_a", o_rva, 1'b1);
        check("b2b_rdata_a", o_rda, 8'h11);
        check("b2b_rdata_b_idle", o_rdb, 8'h00);
        idle(0);
        check("b2b_rvalid_b", o_rvb, 1'b1);
        check("b2b_rdata_b", o_rdb, 8'h22);

        // read right after a write to the same address
        step(0, 1, 0, 1, 0, 4'd5, '0, 8'h77, '0);
        step(0, 0, 1, 0, 0, '0, 4'd5, '0, '0);
        idle(0);
        check("raw_rdata_b", o_rdb, 8'h77);

        // reset in the response cycle discards the read
        step(0, 1, 0, 0, 0, 4'd3, '0, '0, '0);
        idle(1);
        check("rst_drop_rvalid", o_rva, 1'b0);
        step(0, 1, 1, 0, 0, 4'd1, 4'd2, '0, '0);
        check("post_rst_tie_a", o_ga, 1'b1);

        // idle cycles leave memory untouched
        for (int i = 0; i < 5; i++) idle(0);
        mem_compare("idle_mem");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ADDR'($urandom), ADDR'($urandom),
                 WIDTH'($urandom), WIDTH'($urandom));
        end
        idle(0);
        mem_compare("rand_mem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
